regs_bus_arb: RTL and testbench
===============================

Name: regs_bus_arb

Overview:
- Two-master arbiter and sequencer for the register-file bus (address, write data, write strobe, read request/ack).
- Master 0 is the UART command parser; master 1 is an on-chip requester, e.g. a boot/init sequencer.
- Serialises accesses round-robin, converts each master's 4-phase request into one slave bus cycle, and bounds read waits with a timeout.
- Sits between the masters and the register block.

Parameters:
C_DAT_W, 8, data width
C_ADR_W, 4, address width
C_TO_CYC, 200, read timeout in clocks (>=2)

Ports:
CK_i  in  1  clock, rising edge
ARST_i  in  1  asynchronous active-high reset
M0_REQ_i  in  1  master0 request level (4-phase)
M0_WE_i  in  1  master0 1=write 0=read, valid with REQ
M0_ADRs_i  in  C_ADR_W  master0 address
M0_WDATs_i  in  C_DAT_W  master0 write data
M0_ACK_o  out  1  master0 completion, 1-cycle pulse
M0_ERR_o  out  1  master0 read timeout flag, valid with ACK
M0_RDATs_o  out  C_DAT_W  master0 read data, held until next master0 ACK
M1_REQ_i, M1_WE_i, M1_ADRs_i, M1_WDATs_i, M1_ACK_o, M1_ERR_o, M1_RDATs_o  same as master0, for master1
S_ADRs_o  out  C_ADR_W  slave address, held for the whole transaction
S_WDATs_o  out  C_DAT_W  slave write data
S_WT_o  out  1  slave write strobe, 1-cycle pulse
S_RD_REQ_o  out  1  slave read request level
S_RD_ACK_i  in  1  slave read done, 1-cycle pulse with data
S_RDATs_i  in  C_DAT_W  slave read data
GNTs_o  out  2  one-hot grant, bit n = master n
BUSY_o  out  1  FSM not in IDLE

Behaviour:
- Outputs are registered. Reset (async, any state) values:
  - all outputs 0
  - FSM = IDLE
  - LAST = 1, so master0 wins first
  - timeout counter = 0
  - Reset mid-transaction aborts it silently: no ACK, no S_WT_o.
- IDLE:
  - If any REQ is high at edge k, pick the winner. If both are high, the master != LAST wins; otherwise the sole requester wins.
  - Latch WE/ADR/WDAT and set GNTs_o.
  - WE=1: go to WRITE with S_WT_o=1 in cycle k+1.
  - WE=0: go to RD_WAIT with S_RD_REQ_o=1 in cycle k+1, counter cleared.
- WRITE:
  - Single cycle: S_WT_o=1 with latched ADR/WDAT.
  - Next cycle DONE: winner ACK=1, ERR=0.
  - Write latency: REQ sampled at edge k, strobe in cycle k+1, ACK in cycle k+2.
- RD_WAIT:
  - S_RD_REQ_o held high; counter increments each cycle.
  - If S_RD_ACK_i=1: capture S_RDATs_i into winner RDAT, go to DONE with ERR=0, S_RD_REQ_o drops in the same transition.
  - Else if counter == C_TO_CYC-1: RDAT = all ones, go to DONE with ERR=1.
  - If ACK and timeout coincide, ACK wins.
  - A spurious S_RD_ACK_i outside RD_WAIT is ignored.
- DONE:
  - One cycle: winner ACK=1 (ERR valid), LAST = winner.
  - The other master's ACK/ERR/RDAT are untouched.
  - Go to REL.
- REL:
  - GNTs_o stays.
  - Wait until the winner's REQ is low, then IDLE with GNTs_o=0.
  - REQ already low in DONE gives a 1-cycle REL.
- Both requesters continuously requesting (re-raising REQ) alternate 0,1,0,1.
- Winner dropping REQ before ACK: the transaction still completes and ACK is still issued.
- Master inputs are sampled only in IDLE; changes during a transaction are ignored.
- Counter is clog2(C_TO_CYC) bits and saturates; it never wraps.
- GNTs_o is never 2'b11.
- S_WT_o and S_RD_REQ_o are never high together.

Test Plan:
- Reset, then M0 write ADR=3 WDAT=0xA5 -> S_WT_o single pulse 1 cycle after REQ with S_ADRs_o=3, S_WDATs_o=0xA5; M0_ACK_o pulse next cycle; GNTs_o=01; M1 outputs unchanged.
- M1 read ADR=0xF, slave acks after 3 cycles with 0xBC -> S_RD_REQ_o high 4 cycles; M1_RDATs_o=0xBC; M1_ACK_o=1, M1_ERR_o=0; BUSY_o low after REQ drops.
- M0 and M1 raise REQ in the same cycle, both writes, re-requesting after every ACK for 6 transactions -> grant order 0,1,0,1,0,1; no overlapping strobes.
- M0 read, slave never acks, C_TO_CYC=16 -> M0_ACK_o with M0_ERR_o=1 exactly 16 cycles after S_RD_REQ_o rises; M0_RDATs_o=0xFF.
- Slave ack in exactly the timeout cycle -> ERR=0, data captured.
- ARST_i pulsed while in RD_WAIT -> all outputs 0 immediately; no ACK; next request after reset is serviced normally, with M0 first if both request.

Source files
------------

// File: rtl/regs_bus_arb.sv
// regs_bus_arb: two-master arbiter/sequencer for the register-file bus.
//
// Accepts 4-phase requests from master 0 (UART command parser) and master 1
// (on-chip requester), grants them round-robin, turns each request into one
// slave bus cycle (write strobe or read request/ack) and bounds read waits
// with a timeout.
//
// Ports:
//   CK_i, ARST_i                    clock (rising edge), async active-high reset
//   Mn_REQ_i/WE_i/ADRs_i/WDATs_i    master n request level, direction, address, write data
//   Mn_ACK_o/ERR_o/RDATs_o          master n completion pulse, timeout flag, read data
//   S_ADRs_o/S_WDATs_o              slave address / write data, held per transaction
//   S_WT_o, S_RD_REQ_o              slave write strobe pulse, read request level
//   S_RD_ACK_i, S_RDATs_i           slave read done pulse and read data
//   GNTs_o, BUSY_o                  one-hot grant, sequencer busy
module regs_bus_arb #(
    parameter int C_DAT_W  = 8,
    parameter int C_ADR_W  = 4,
    parameter int C_TO_CYC = 200
) (
    input  logic               CK_i,
    input  logic               ARST_i,
    input  logic               M0_REQ_i,
    input  logic               M0_WE_i,
    input  logic [C_ADR_W-1:0] M0_ADRs_i,
    input  logic [C_DAT_W-1:0] M0_WDATs_i,
    output logic               M0_ACK_o,
    output logic               M0_ERR_o,
    output logic [C_DAT_W-1:0] M0_RDATs_o,
    input  logic               M1_REQ_i,
    input  logic               M1_WE_i,
    input  logic [C_ADR_W-1:0] M1_ADRs_i,
    input  logic [C_DAT_W-1:0] M1_WDATs_i,
    output logic               M1_ACK_o,
    output logic               M1_ERR_o,
    output logic [C_DAT_W-1:0] M1_RDATs_o,
    output logic [C_ADR_W-1:0] S_ADRs_o,
    output logic [C_DAT_W-1:0] S_WDATs_o,
    output logic               S_WT_o,
    output logic               S_RD_REQ_o,
    input  logic               S_RD_ACK_i,
    input  logic [C_DAT_W-1:0] S_RDATs_i,
    output logic [1:0]         GNTs_o,
    output logic               BUSY_o
);

    localparam int C_CNT_W = (C_TO_CYC > 1) ? $clog2(C_TO_CYC) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(C_TO_CYC - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_SAT  = {C_CNT_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_DONE    = 3'd3,
        ST_REL     = 3'd4
    } state_t;

    state_t                   r_state;
    logic                     r_last;
    logic                     r_win;
    logic                     r_we;
    logic [C_CNT_W-1:0]       r_cnt;
    logic [C_ADR_W-1:0]       r_adr;
    logic [C_DAT_W-1:0]       r_wdat;
    logic                     r_wt;
    logic                     r_rd_req;
    logic                     r_busy;
    logic [1:0]               r_gnt;
    logic [1:0]               r_ack;
    logic [1:0]               r_err;
    logic [1:0][C_DAT_W-1:0]  r_rdat;

    logic                     w_any_req;
    logic                     w_win;
    logic                     w_win_we;
    logic [C_ADR_W-1:0]       w_win_adr;
    logic [C_DAT_W-1:0]       w_win_wdat;
    logic                     w_win_req;

    // Arbitration: on contention the master that was not served last wins.
    always_comb begin
        w_any_req = M0_REQ_i | M1_REQ_i;
        if (M0_REQ_i && M1_REQ_i) begin
            w_win = ~r_last;
        end else begin
            w_win = M1_REQ_i;
        end
        if (w_win) begin
            w_win_we   = M1_WE_i;
            w_win_adr  = M1_ADRs_i;
            w_win_wdat = M1_WDATs_i;
        end else begin
            w_win_we   = M0_WE_i;
            w_win_adr  = M0_ADRs_i;
            w_win_wdat = M0_WDATs_i;
        end
    end

    assign w_win_req = r_win ? M1_REQ_i : M0_REQ_i;

    // Transaction sequencer with all bus and master outputs registered.
    always_ff @(posedge CK_i or posedge ARST_i) begin
        if (ARST_i) begin
            r_state  <= ST_IDLE;
            r_last   <= 1'b1;
            r_win    <= 1'b0;
            r_we     <= 1'b0;
            r_cnt    <= '0;
            r_adr    <= '0;
            r_wdat   <= '0;
            r_wt     <= 1'b0;
            r_rd_req <= 1'b0;
            r_busy   <= 1'b0;
            r_gnt    <= 2'b00;
            r_ack    <= 2'b00;
            r_err    <= 2'b00;
            r_rdat   <= '0;
        end else begin
            r_wt  <= 1'b0;
            r_ack <= 2'b00;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_win  <= w_win;
                        r_we   <= w_win_we;
                        r_adr  <= w_win_adr;
                        r_wdat <= w_win_wdat;
                        r_gnt  <= w_win ? 2'b10 : 2'b01;
                        r_busy <= 1'b1;
                        r_cnt  <= '0;
                        if (w_win_we) begin
                            r_wt    <= 1'b1;
                            r_state <= ST_WRITE;
                        end else begin
                            r_rd_req <= 1'b1;
                            r_state  <= ST_RD_WAIT;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    r_ack[r_win] <= 1'b1;
                    r_err[r_win] <= 1'b0;
                    r_state      <= ST_DONE;
                end
                ST_RD_WAIT: begin
                    // A slave ack in the timeout cycle still counts as success.
                    if (S_RD_ACK_i) begin
                        r_rd_req      <= 1'b0;
                        r_ack[r_win]  <= 1'b1;
                        r_err[r_win]  <= 1'b0;
                        r_rdat[r_win] <= S_RDATs_i;
                        r_state       <= ST_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_rd_req      <= 1'b0;
                        r_ack[r_win]  <= 1'b1;
                        r_err[r_win]  <= 1'b1;
                        r_rdat[r_win] <= {C_DAT_W{1'b1}};
                        r_state       <= ST_DONE;
                    end else if (r_cnt != C_CNT_SAT) begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                ST_DONE: begin
                    r_last  <= r_win;
                    r_state <= ST_REL;
                end
                ST_REL: begin
                    // Hold the grant until the winner finishes its handshake.
                    if (!w_win_req) begin
                        r_gnt   <= 2'b00;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_REL;
                    end
                end
                default: begin
                    r_gnt    <= 2'b00;
                    r_busy   <= 1'b0;
                    r_rd_req <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign M0_ACK_o   = r_ack[0];
    assign M0_ERR_o   = r_err[0];
    assign M0_RDATs_o = r_rdat[0];
    assign M1_ACK_o   = r_ack[1];
    assign M1_ERR_o   = r_err[1];
    assign M1_RDATs_o = r_rdat[1];
    assign S_ADRs_o   = r_adr;
    assign S_WDATs_o  = r_wdat;
    assign S_WT_o     = r_wt;
    assign S_RD_REQ_o = r_rd_req;
    assign GNTs_o     = r_gnt;
    assign BUSY_o     = r_busy;

endmodule

// File: tb/tb_regs_bus_arb.sv
`timescale 1ns/1ps
module tb_regs_bus_arb;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int TO = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] wdat;
        logic          early;
    } txn_t;

    logic          clk  = 1'b0;
    logic          arst = 1'b1;
    logic [1:0]    m_req = 2'b00;
    logic [1:0]    m_we  = 2'b00;
    logic [AW-1:0] m_adr0 = '0, m_adr1 = '0;
    logic [DW-1:0] m_wdat0 = '0, m_wdat1 = '0;
    logic [1:0]    m_early = 2'b00;
    logic          s_ack = 1'b0;
    logic [DW-1:0] s_dat = '0;

    logic          ack0, ack1, err0, err1, s_wt, s_rdreq, busy;
    logic [DW-1:0] rdat0, rdat1, s_wdat;
    logic [AW-1:0] s_adr;
    logic [1:0]    gnt;

    regs_bus_arb #(.C_DAT_W(DW), .C_ADR_W(AW), .C_TO_CYC(TO)) dut (
        .CK_i(clk), .ARST_i(arst),
        .M0_REQ_i(m_req[0]), .M0_WE_i(m_we[0]), .M0_ADRs_i(m_adr0), .M0_WDATs_i(m_wdat0),
        .M0_ACK_o(ack0), .M0_ERR_o(err0), .M0_RDATs_o(rdat0),
        .M1_REQ_i(m_req[1]), .M1_WE_i(m_we[1]), .M1_ADRs_i(m_adr1), .M1_WDATs_i(m_wdat1),
        .M1_ACK_o(ack1), .M1_ERR_o(err1), .M1_RDATs_o(rdat1),
        .S_ADRs_o(s_adr), .S_WDATs_o(s_wdat), .S_WT_o(s_wt), .S_RD_REQ_o(s_rdreq),
        .S_RD_ACK_i(s_ack), .S_RDATs_i(s_dat), .GNTs_o(gnt), .BUSY_o(busy)
    );

    initial forever #5 clk = ~clk;

    // ---------------- counters / checker ----------------
    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // ---------------- master and slave stimulus ----------------
    txn_t q0[$];
    txn_t q1[$];
    int   slv_lat = 0;        // 0 = slave never answers
    logic [DW-1:0] slv_dat = '0;
    logic spur = 1'b0;        // drive S_RD_ACK_i while no read is outstanding
    int   rdcnt = 0;

    initial forever begin
        @(negedge clk);
        if (arst) begin
            q0.delete(); q1.delete();
            m_req = 2'b00;
        end else begin
            // master 0: 4-phase, re-raise only after the grant is released
            if (ack0) begin
                if (q0.size() > 0) q0.delete(0);
                m_req[0] = 1'b0;
            end else if (m_req[0] && gnt[0]) begin
                m_we[0] = ~m_we[0]; m_adr0 = ~m_adr0; m_wdat0 = ~m_wdat0;
                if (m_early[0]) m_req[0] = 1'b0;
            end else if (!m_req[0] && !gnt[0] && q0.size() > 0) begin
                m_we[0] = q0[0].we; m_adr0 = q0[0].adr; m_wdat0 = q0[0].wdat;
                m_early[0] = q0[0].early; m_req[0] = 1'b1;
            end
            // master 1
            if (ack1) begin
                if (q1.size() > 0) q1.delete(0);
                m_req[1] = 1'b0;
            end else if (m_req[1] && gnt[1]) begin
                m_we[1] = ~m_we[1]; m_adr1 = ~m_adr1; m_wdat1 = ~m_wdat1;
                if (m_early[1]) m_req[1] = 1'b0;
            end else if (!m_req[1] && !gnt[1] && q1.size() > 0) begin
                m_we[1] = q1[0].we; m_adr1 = q1[0].adr; m_wdat1 = q1[0].wdat;
                m_early[1] = q1[0].early; m_req[1] = 1'b1;
            end
        end
        // slave: answer on the slv_lat-th cycle of the read request
        if (s_rdreq) begin
            rdcnt++;
            s_ack = (rdcnt == slv_lat);
            s_dat = (rdcnt == slv_lat) ? slv_dat : 8'h00;
        end else begin
            rdcnt = 0;
            s_ack = spur;
            s_dat = spur ? 8'h77 : 8'h00;
        end
    end

    // ---------------- transaction-level reference model ----------------
    // md: 0 = bus free, 1 = transaction in flight, 2 = waiting for winner's REQ to drop
    int            md = 0;
    int            last = 1;
    int            win = 0;
    int            g = 0;      // cycle of the grant (first bus cycle)
    int            n = 1;      // bus cycles before the ACK cycle
    logic          t_we = 1'b0, t_to = 1'b0;
    logic [AW-1:0] t_adr = '0;
    logic [DW-1:0] t_wdat = '0, t_sdat = '0;
    logic [DW-1:0] e_rdat0 = '0, e_rdat1 = '0;
    logic [1:0]    e_err = 2'b00;

    initial forever begin
        @(posedge clk or posedge arst);
        if (arst) begin
            md = 0; last = 1; e_rdat0 = '0; e_rdat1 = '0; e_err = 2'b00;
        end else begin
            cyc++;
            if (md == 0) begin
                if (m_req != 2'b00) begin
                    win    = (m_req == 2'b11) ? ((last == 0) ? 1 : 0) : (m_req[1] ? 1 : 0);
                    t_we   = m_we[win];
                    t_adr  = (win == 1) ? m_adr1 : m_adr0;
                    t_wdat = (win == 1) ? m_wdat1 : m_wdat0;
                    g      = cyc;
                    if (t_we) begin n = 1; t_to = 1'b0; end
                    else if (slv_lat == 0 || slv_lat > TO) begin n = TO; t_to = 1'b1; end
                    else begin n = slv_lat; t_to = 1'b0; end
                    t_sdat = slv_dat;
                    md = 1;
                end
            end else if (md == 1) begin
                if (cyc == g + n) begin
                    e_err[win] = !t_we && t_to;
                    if (!t_we) begin
                        if (win == 1) e_rdat1 = t_to ? 8'hFF : t_sdat;
                        else          e_rdat0 = t_to ? 8'hFF : t_sdat;
                    end
                end else if (cyc == g + n + 1) begin
                    md = 2; last = win;
                end
            end else if (!m_req[win]) begin
                md = 0;
            end
        end
    end

    // ---------------- per-cycle compare + observation statistics ----------------
    int   wt_cnt, rq_cnt, wt_first, rq_first, ack_cnt0, ack_cnt1, ack_cyc0, ack_cyc1;
    logic err_seen0, err_seen1, overlap, g11;
    int   gorder[$];
    logic [1:0] prev_gnt = 2'b00;

    task automatic clr_stats();
        wt_cnt = 0; rq_cnt = 0; wt_first = -1; rq_first = -1;
        ack_cnt0 = 0; ack_cnt1 = 0; ack_cyc0 = 0; ack_cyc1 = 0;
        err_seen0 = 1'b0; err_seen1 = 1'b0; overlap = 1'b0; g11 = 1'b0;
        gorder.delete();
    endtask

    function automatic int gidx(input int i);
        return (gorder.size() > i) ? gorder[i] : 9;
    endfunction

    initial forever begin
        logic [1:0] e_gnt, e_ack;
        logic e_wt, e_rq;
        @(negedge clk);
        if (!arst) begin
            e_gnt = (md != 0) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_wt  = (md == 1) && t_we && (cyc == g);
            e_rq  = (md == 1) && !t_we && (cyc >= g) && (cyc < g + n);
            e_ack = ((md == 1) && (cyc == g + n)) ? ((win == 1) ? 2'b10 : 2'b01) : 2'b00;
            chk("gnt", gnt, e_gnt);
            chk("busy", busy, md != 0);
            chk("s_wt", s_wt, e_wt);
            chk("s_rd_req", s_rdreq, e_rq);
            chk("ack", {ack1, ack0}, e_ack);
            chk("rdat0", rdat0, e_rdat0);
            chk("rdat1", rdat1, e_rdat1);
            if (e_ack[0]) chk("err0", err0, e_err[0]);
            if (e_ack[1]) chk("err1", err1, e_err[1]);
            if (e_wt || e_rq) chk("s_adr", s_adr, t_adr);
            if (e_wt) chk("s_wdat", s_wdat, t_wdat);
            wt_cnt += s_wt;
            rq_cnt += s_rdreq;
            if (s_wt && wt_first < 0) wt_first = cyc;
            if (s_rdreq && rq_first < 0) rq_first = cyc;
            if (ack0) begin ack_cnt0++; ack_cyc0 = cyc; err_seen0 = err0; end
            if (ack1) begin ack_cnt1++; ack_cyc1 = cyc; err_seen1 = err1; end
            if (gnt != 2'b00 && prev_gnt == 2'b00) gorder.push_back(gnt[1] ? 1 : 0);
            overlap |= s_wt & s_rdreq;
            g11 |= (gnt == 2'b11);
        end
        prev_gnt = gnt;
    end

    // ---------------- directed test sequence ----------------
    task automatic push(input int m, input logic we, input logic [AW-1:0] adr,
                        input logic [DW-1:0] wdat, input logic early);
        txn_t t;
        t.we = we; t.adr = adr; t.wdat = wdat; t.early = early;
        if (m == 0) q0.push_back(t); else q1.push_back(t);
    endtask

    task automatic wait_idle(input string nm, input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #2;
            if (q0.size() == 0 && q1.size() == 0 && m_req == 2'b00 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1'b1);
    endtask

    initial begin
        clr_stats();
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk); #2;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_busy_acks", {busy, ack1, ack0, err1, err0, s_wt, s_rdreq}, 7'd0);
        chk("rst_rdat", {rdat1, rdat0}, 16'h0000);

        // T1: M0 write ADR=3 WDAT=A5
        clr_stats(); push(0, 1'b1, 4'h3, 8'hA5, 1'b0);
        wait_idle("t1_idle", 60);
        chk("t1_wt_cnt", wt_cnt, 1);
        chk("t1_ack_lat", ack_cyc0 - wt_first, 1);
        chk("t1_acks", {ack_cnt1[7:0], ack_cnt0[7:0]}, 16'h0001);
        chk("t1_grant", gidx(0), 0);

        // T2: M1 read ADR=F, slave answers 0xBC on 4th request cycle
        clr_stats(); slv_lat = 4; slv_dat = 8'hBC; push(1, 1'b0, 4'hF, 8'h00, 1'b0);
        wait_idle("t2_idle", 60);
        chk("t2_rdreq_cycles", rq_cnt, 4);
        chk("t2_rdat1", rdat1, 8'hBC);
        chk("t2_err1", err_seen1, 1'b0);
        chk("t2_ack1_cnt", ack_cnt1, 1);

        // T3: both masters, 3 writes each, continuous re-request
        clr_stats();
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b1, AW'(i), DW'(8'h10 + i), 1'b0);
            push(1, 1'b1, AW'(8 + i), DW'(8'h20 + i), 1'b0);
        end
        wait_idle("t3_idle", 200);
        chk("t3_grants", gorder.size(), 6);
        for (int i = 0; i < 6; i++) chk("t3_order", gidx(i), i % 2);
        chk("t3_overlap_or_gnt11", {overlap, g11}, 2'b00);
        chk("t3_wt_cnt", wt_cnt, 6);

        // T4: M0 read, slave silent -> timeout
        clr_stats(); slv_lat = 0; push(0, 1'b0, 4'h7, 8'h00, 1'b0);
        wait_idle("t4_idle", 100);
        chk("t4_rdreq_cycles", rq_cnt, 16);
        chk("t4_ack_delay", ack_cyc0 - rq_first, 16);
        chk("t4_rdat0", rdat0, 8'hFF);
        chk("t4_err0", err_seen0, 1'b1);

        // T5: M1 read, slave answers in the timeout cycle itself
        clr_stats(); slv_lat = 16; slv_dat = 8'h3C; push(1, 1'b0, 4'h2, 8'h00, 1'b0);
        wait_idle("t5_idle", 100);
        chk("t5_err1", err_seen1, 1'b0);
        chk("t5_rdat1", rdat1, 8'h3C);
        chk("t5_ack_delay", ack_cyc1 - rq_first, 16);

        // T6: early REQ drop (read then write), spurious slave acks around the write
        clr_stats(); slv_lat = 2; slv_dat = 8'h5E; push(1, 1'b0, 4'hC, 8'h00, 1'b1);
        wait_idle("t6a_idle", 60);
        chk("t6_rdat1", rdat1, 8'h5E);
        chk("t6_ack1_cnt", ack_cnt1, 1);
        clr_stats(); spur = 1'b1; push(0, 1'b1, 4'h5, 8'h11, 1'b1);
        wait_idle("t6b_idle", 60);
        spur = 1'b0;
        chk("t6_ack0_cnt", ack_cnt0, 1);
        chk("t6_rdat0_kept", rdat0, 8'hFF);

        // T7: reset while M0 waits for read data
        clr_stats(); slv_lat = 0; push(0, 1'b0, 4'h9, 8'h00, 1'b0);
        for (int i = 0; i < 20 && !s_rdreq; i++) @(negedge clk);
        chk("t7_in_rd_wait", s_rdreq, 1'b1);
        repeat (3) @(posedge clk);
        #1 arst = 1'b1;
        #1;
        chk("t7_rst_ctl", {gnt, busy, ack1, ack0, err1, err0, s_wt, s_rdreq}, 9'd0);
        chk("t7_rst_data", {rdat1, rdat0, s_wdat}, 24'd0);
        chk("t7_rst_adr", s_adr, 4'h0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        @(negedge clk); #2;
        chk("t7_no_ack", ack_cnt0 + ack_cnt1, 0);
        clr_stats();
        push(0, 1'b1, 4'h1, 8'h5A, 1'b0);
        push(1, 1'b1, 4'h2, 8'hC3, 1'b0);
        wait_idle("t7_idle", 60);
        chk("t7_grants", gorder.size(), 2);
        chk("t7_first", gidx(0), 0);
        chk("t7_second", gidx(1), 1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule
